// File: rtl/param_store.sv
// param_store: parameter register file and write-back sequencer.
// It holds all weights (wall) and biases (ball) of a SX-SL1-SL network and
// presents them packed. It gates per-sample accumulation (ACC: all slots
// enabled, dtb=0), then walks a one-hot write-back (UPD: one slot per cycle,
// dtb=1), capturing each updated word from bus[N-1:0]. When the walk ends it
// issues a one-cycle accumulator clear (CLR) with a done pulse.
// The bus is listened to only; this block never drives it.
// Optional feature: define PARAM_STORE_CLAMP_EN to saturate every captured
// word to [-CLAMP, +CLAMP] (signed) before it is written.
module param_store #(
  parameter int          N     = 32,
  parameter int          SX    = 2,
  parameter int          SL1   = 3,
  parameter int          SL    = 2,
  parameter int          WT    = SX*SL1 + SL1*SL,
  parameter int          ND    = SL1 + SL,
  parameter logic [N-1:0] CLAMP = 'h7F000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_en,
  input  logic [N*WT-1:0]   init_wall,
  input  logic [N*ND-1:0]   init_ball,
  input  logic              acc_req,
  input  logic              start,
  output logic [WT+ND-1:0]  we,
  output logic              dtb,
  inout  wire  [2*N-1:0]    bus,
  output logic [N*WT-1:0]   wall,
  output logic [N*ND-1:0]   ball,
  output logic              acc_clr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       epoch
);

  localparam int S  = WT + ND;
  localparam int CW = $clog2(S);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_UPD, S_CLR} state_t;

  // Destination of one write-back slot: a bias word or a weight word.
  typedef struct packed {
    logic        is_bias;
    logic [31:0] idx;
  } slot_t;

  // Slot order: for each layer-1 node its SX weights then its bias, then for
  // each layer-2 node its SL1 weights then its bias.
  function automatic slot_t slot_map(input int s);
    slot_t m;
    int    l1_span;
    int    t;
    int    k;
    int    r;
    l1_span = SL1 * (SX + 1);
    if (s < l1_span) begin
      k         = s / (SX + 1);
      r         = s % (SX + 1);
      m.is_bias = (r == SX);
      m.idx     = (r == SX) ? 32'(k) : 32'(k*SX + r);
    end else begin
      t         = s - l1_span;
      k         = t / (SL1 + 1);
      r         = t % (SL1 + 1);
      m.is_bias = (r == SL1);
      m.idx     = (r == SL1) ? 32'(SL1 + k) : 32'(SX*SL1 + k*SL1 + r);
    end
    return m;
  endfunction

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [S-1:0]      we_q;
  logic              dtb_q;
  logic              acc_clr_q;
  logic              done_q;
  logic              busy_q;
  logic [15:0]       epoch_q;
  logic [N*WT-1:0]   wall_q, wall_d;
  logic [N*ND-1:0]   ball_q, ball_d;

  logic [WT-1:0]     w_en;
  logic [ND-1:0]     b_en;
  logic [N-1:0]      bus_word;
  logic [N-1:0]      cap_word;
  logic [N-1:0]      unused_bus_hi;

  assign bus_word      = bus[N-1:0];
  assign unused_bus_hi = bus[2*N-1:N];

  // Per-slot write enables, routed to the word each slot maps to.
  for (genvar s = 0; s < S; s++) begin : g_slot
    localparam slot_t M = slot_map(s);
    if (M.is_bias) begin : g_b
      assign b_en[M.idx] = (state_q == S_UPD) && (cnt_q == CW'(s));
    end else begin : g_w
      assign w_en[M.idx] = (state_q == S_UPD) && (cnt_q == CW'(s));
    end
  end

`ifdef PARAM_STORE_CLAMP_EN
  // Saturate the captured bus word to the signed range [-CLAMP, +CLAMP].
  always_comb begin
    cap_word = bus_word;
    if ($signed(bus_word) > $signed(CLAMP)) begin
      cap_word = CLAMP;
    end else if ($signed(bus_word) < -$signed(CLAMP)) begin
      cap_word = -CLAMP;
    end
  end
`else
  logic [N-1:0] unused_clamp;
  assign unused_clamp = CLAMP;
  assign cap_word     = bus_word;
`endif

  // Next register-file contents: init load in IDLE, or one slot write in UPD.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise a latch is inferred.
    wall_d = wall_q;
    ball_d = ball_q;
    if (state_q == S_IDLE && init_en && !start) begin
      wall_d = init_wall;
      ball_d = init_ball;
    end
    for (int j = 0; j < WT; j++) begin
      if (w_en[j]) wall_d[j*N +: N] = cap_word;
    end
    for (int j = 0; j < ND; j++) begin
      if (b_en[j]) ball_d[j*N +: N] = cap_word;
    end
  end

  // Sequencer FSM with registered outputs, plus the register file itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is reset too; reset contents must be zero,
      // not the init values, so these flops cannot be left reset-free.
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= '0;
      dtb_q     <= 1'b0;
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      epoch_q   <= '0;
      wall_q    <= '0;
      ball_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every flop samples the
      // pre-edge values, independent of statement order.
      wall_q    <= wall_d;
      ball_q    <= ball_d;
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_UPD;
            cnt_q   <= '0;
            we_q    <= S'(1);
            dtb_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (acc_req) begin
            state_q <= S_ACC;
            we_q    <= '1;
            dtb_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            we_q    <= '0;
            dtb_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        S_ACC: begin
          state_q <= S_IDLE;
          we_q    <= '0;
          dtb_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        S_UPD: begin
          if (cnt_q == CW'(S-1)) begin
            state_q   <= S_CLR;
            cnt_q     <= '0;
            we_q      <= '0;
            dtb_q     <= 1'b0;
            acc_clr_q <= 1'b1;
            done_q    <= 1'b1;
            epoch_q   <= epoch_q + 16'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            we_q  <= we_q << 1;
          end
        end
        S_CLR: begin
          state_q <= S_IDLE;
          we_q    <= '0;
          dtb_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= '0;
          dtb_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign we      = we_q;
  assign dtb     = dtb_q;
  assign acc_clr = acc_clr_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign epoch   = epoch_q;
  assign wall    = wall_q;
  assign ball    = ball_q;

endmodule

// File: tb/tb_param_store.sv
// Self-checking bench for param_store: a word-array model driven by the
// directed stimulus, compared against the DUT on every falling edge, plus
// hand-computed literal checks.
module tb_param_store;

  localparam int N  = 32;
  localparam int WT = 12;
  localparam int ND = 5;
  localparam int S  = WT + ND;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_en;
  logic [N*WT-1:0]   init_wall;
  logic [N*ND-1:0]   init_ball;
  logic              acc_req;
  logic              start;
  logic [S-1:0]      we;
  logic              dtb;
  wire  [2*N-1:0]    bus;
  logic [2*N-1:0]    bus_drv;
  logic [N*WT-1:0]   wall;
  logic [N*ND-1:0]   ball;
  logic              acc_clr;
  logic              busy;
  logic              done;
  logic [15:0]       epoch;

  assign bus = bus_drv;

  always #5 clk = ~clk;

  param_store dut (
    .clk       (clk),
    .rst       (rst),
    .init_en   (init_en),
    .init_wall (init_wall),
    .init_ball (init_ball),
    .acc_req   (acc_req),
    .start     (start),
    .we        (we),
    .dtb       (dtb),
    .bus       (bus),
    .wall      (wall),
    .ball      (ball),
    .acc_clr   (acc_clr),
    .busy      (busy),
    .done      (done),
    .epoch     (epoch)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [S-1:0] exp_we;
  logic         exp_dtb, exp_busy, exp_done, exp_clr;
  logic [15:0]  m_epoch;
  logic [31:0]  m_w [WT];
  logic [31:0]  m_b [ND];
  bit           slot_is_b [S];
  int           slot_idx  [S];
  logic [31:0]  bus_vals  [S];

  task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
`ifdef PARAM_STORE_CLAMP_EN
    if ($signed(v) > $signed(32'h7F000000)) return 32'h7F000000;
    if ($signed(v) < $signed(32'h81000000)) return 32'h81000000;
`endif
    return v;
  endfunction

  function automatic logic [N*WT-1:0] pack_w();
    logic [N*WT-1:0] r;
    for (int j = 0; j < WT; j++) r[j*N +: N] = m_w[j];
    return r;
  endfunction

  function automatic logic [N*ND-1:0] pack_b();
    logic [N*ND-1:0] r;
    for (int j = 0; j < ND; j++) r[j*N +: N] = m_b[j];
    return r;
  endfunction

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("we",      384'(we),      384'(exp_we));
      check("dtb",     384'(dtb),     384'(exp_dtb));
      check("busy",    384'(busy),    384'(exp_busy));
      check("done",    384'(done),    384'(exp_done));
      check("acc_clr", 384'(acc_clr), 384'(exp_clr));
      check("epoch",   384'(epoch),   384'(m_epoch));
      check("wall",    384'(wall),    384'(pack_w()));
      check("ball",    384'(ball),    384'(pack_b()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_we   = '0;
    exp_dtb  = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_clr  = 1'b0;
  endtask

  task automatic zero_model();
    for (int j = 0; j < WT; j++) m_w[j] = '0;
    for (int j = 0; j < ND; j++) m_b[j] = '0;
    m_epoch = '0;
  endtask

  task automatic capture(input int c);
    if (slot_is_b[c]) m_b[slot_idx[c]] = sat(bus_vals[c]);
    else              m_w[slot_idx[c]] = sat(bus_vals[c]);
  endtask

  // Full write-back; noisy adds same-cycle acc_req/init_en and requests
  // during the walk, all of which must be ignored.
  task automatic writeback(input bit noisy);
    start = 1'b1;
    if (noisy) begin
      acc_req = 1'b1;
      init_en = 1'b1;
    end
    tick();
    start   = 1'b0;
    acc_req = 1'b0;
    init_en = 1'b0;
    for (int c = 0; c < S; c++) begin
      exp_we   = S'(1) << c;
      exp_dtb  = 1'b1;
      exp_busy = 1'b1;
      exp_done = 1'b0;
      exp_clr  = 1'b0;
      bus_drv[31:0] = bus_vals[c];
      acc_req = noisy && (c % 5 == 2);
      start   = noisy && (c == 7);
      init_en = noisy && (c == 12);
      tick();
      capture(c);
    end
    acc_req  = 1'b0;
    start    = 1'b0;
    init_en  = 1'b0;
    exp_we   = '0;
    exp_dtb  = 1'b0;
    exp_busy = 1'b1;
    exp_done = 1'b1;
    exp_clr  = 1'b1;
    m_epoch  = m_epoch + 16'd1;
    tick();
    idle_exp();
    bus_drv[31:0] = '0;
  endtask

  initial begin
    // Slot map built by walking the network node by node.
    begin
      int s = 0;
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 2; i++) begin slot_is_b[s] = 0; slot_idx[s] = k*2 + i; s++; end
        slot_is_b[s] = 1; slot_idx[s] = k; s++;
      end
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) begin slot_is_b[s] = 0; slot_idx[s] = 6 + k*3 + i; s++; end
        slot_is_b[s] = 1; slot_idx[s] = 3 + k; s++;
      end
    end

    rst       = 1'b1;
    init_en   = 1'b0;
    acc_req   = 1'b0;
    start     = 1'b0;
    init_wall = '0;
    init_ball = '0;
    bus_drv   = {32'hDEADBEEF, 32'h0};
    zero_model();
    idle_exp();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wall", 384'(wall), 384'(0));
    check("rst_epoch", 384'(epoch), 384'(0));
    tick();

    // Init load
    for (int j = 0; j < WT; j++) init_wall[j*N +: N] = 32'(j) << 24;
    for (int j = 0; j < ND; j++) init_ball[j*N +: N] = 32'h00800000;
    init_en = 1'b1;
    tick();
    init_en = 1'b0;
    for (int j = 0; j < WT; j++) m_w[j] = 32'(j) << 24;
    for (int j = 0; j < ND; j++) m_b[j] = 32'h00800000;
    check("init_w5", 384'(wall[5*N +: N]), 384'(32'h05000000));
    check("init_b4", 384'(ball[4*N +: N]), 384'(32'h00800000));
    check("init_busy", 384'(busy), 384'(0));
    check("init_we", 384'(we), 384'(0));
    tick();

    // Single accumulate request
    acc_req = 1'b1;
    tick();
    acc_req  = 1'b0;
    exp_we   = '1;
    exp_busy = 1'b1;
    check("acc_we", 384'(we), 384'(17'h1FFFF));
    tick();
    idle_exp();
    tick();

    // Held acc_req: ACC every other cycle
    acc_req = 1'b1;
    tick(); exp_we = '1; exp_busy = 1'b1;
    tick(); idle_exp();
    tick(); exp_we = '1; exp_busy = 1'b1;
    acc_req = 1'b0;
    tick(); idle_exp();
    tick();

    // Plain write-back
    for (int c = 0; c < S; c++) bus_vals[c] = 32'h100 + 32'(c);
    writeback(1'b0);
    check("wb_w0",  384'(wall[0*N +: N]),  384'(32'h100));
    check("wb_b0",  384'(ball[0*N +: N]),  384'(32'h102));
    check("wb_w2",  384'(wall[2*N +: N]),  384'(32'h103));
    check("wb_b4",  384'(ball[4*N +: N]),  384'(32'h110));
    check("wb_w11", 384'(wall[11*N +: N]), 384'(32'h10F));
    check("wb_epoch", 384'(epoch), 384'(1));
    tick();

    // Write-back with colliding and ignored requests
    for (int j = 0; j < WT; j++) init_wall[j*N +: N] = 32'hFFFFFFFF;
    for (int c = 0; c < S; c++) bus_vals[c] = 32'h300 + 32'(c);
    writeback(1'b1);
    check("noisy_epoch", 384'(epoch), 384'(2));
    check("noisy_w6", 384'(wall[6*N +: N]), 384'(32'h309));
    tick();

    // Reset during slot 7
    for (int c = 0; c < S; c++) bus_vals[c] = 32'h500 + 32'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      exp_we   = S'(1) << c;
      exp_dtb  = 1'b1;
      exp_busy = 1'b1;
      bus_drv[31:0] = bus_vals[c];
      if (c == 7) rst = 1'b1;
      tick();
      if (c < 7) capture(c);
    end
    rst = 1'b0;
    zero_model();
    idle_exp();
    bus_drv[31:0] = '0;
    check("abort_epoch", 384'(epoch), 384'(0));
    check("abort_wall", 384'(wall), 384'(0));
    check("abort_we", 384'(we), 384'(0));
    tick();
    tick();

    // Saturation boundary values
    for (int c = 0; c < S; c++) bus_vals[c] = 32'h200 + 32'(c);
    bus_vals[0] = 32'h7FFFFFFF;
    bus_vals[1] = 32'h80000000;
    writeback(1'b0);
`ifdef PARAM_STORE_CLAMP_EN
    check("clamp_w0", 384'(wall[0*N +: N]), 384'(32'h7F000000));
    check("clamp_w1", 384'(wall[1*N +: N]), 384'(32'h81000000));
`else
    check("raw_w0", 384'(wall[0*N +: N]), 384'(32'h7FFFFFFF));
    check("raw_w1", 384'(wall[1*N +: N]), 384'(32'h80000000));
`endif
    check("final_epoch", 384'(epoch), 384'(1));
    tick();
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
